// File: rtl/mem_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_bus_arbiter_pkg
// Brief   : Shared types for the fetch/data memory bus arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package mem_bus_arbiter_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ADDR = 2'd1,
        ARB_WAIT = 2'd2,
        ARB_RESP = 2'd3
    } arb_state_t;

    typedef enum logic {
        SRC_I = 1'b0,
        SRC_D = 1'b1
    } arb_src_t;

    localparam int unsigned TMO_CNT_W = 16;

endpackage
`default_nettype wire

// File: rtl/mem_bus_arbiter_timeout.sv
`default_nettype none
// ============================================================================
// Module  : arb_timeout
// Brief   : Load/enable cycle counter flagging when a transaction overstays.
// Revision: 1.0 - initial release
// ============================================================================
module arb_timeout
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic resetn,
    input  logic load,
    input  logic en,
    output logic expired
);

    localparam logic [TMO_CNT_W-1:0] LAST = TMO_CNT_W'(LIMIT - 1);
    localparam logic [TMO_CNT_W-1:0] ONE  = TMO_CNT_W'(1);

    logic [TMO_CNT_W-1:0] cnt_q;
    logic [TMO_CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = '0;
        end else if (en && (cnt_q != '1)) begin
            cnt_d = cnt_q + ONE;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // >= rather than ==: a handshake that beats the timeout in ADDR can carry
    // the count past LAST, and WAIT must still be able to expire afterwards.
    assign expired = en && (cnt_q >= LAST);

endmodule
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_bus_arbiter
// Brief   : Shares one memory bus between CPU fetch and data ports, data first.
// Revision: 1.0 - initial release
// ============================================================================
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT  = 255,
    parameter word_t       ERR_DATA = 32'hdead_beef
) (
    input  logic  clk,
    input  logic  resetn,
    input  logic  i_req,
    input  word_t i_addr,
    output word_t i_rdata,
    output logic  i_done,
    input  logic  d_req,
    input  logic  d_we,
    input  word_t d_addr,
    input  word_t d_wdata,
    output word_t d_rdata,
    output logic  d_done,
    output logic  stall,
    output logic  bus_valid,
    output logic  bus_we,
    output word_t bus_addr,
    output word_t bus_wdata,
    input  logic  bus_ready,
    input  logic  bus_rvalid,
    input  word_t bus_rdata,
    output logic  timeout_err
);

    arb_state_t state_q, state_d;
    arb_src_t   src_q, src_d;
    logic       bus_valid_q, bus_valid_d;
    logic       bus_we_q, bus_we_d;
    word_t      bus_addr_q, bus_addr_d;
    word_t      bus_wdata_q, bus_wdata_d;
    word_t      i_rdata_q, i_rdata_d;
    word_t      d_rdata_q, d_rdata_d;
    logic       i_done_q, i_done_d;
    logic       d_done_q, d_done_d;
    logic       timeout_err_q, timeout_err_d;

    logic tmo_load;
    logic tmo_en;
    logic tmo_expired;

    arb_timeout #(
        .LIMIT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .resetn  (resetn),
        .load    (tmo_load),
        .en      (tmo_en),
        .expired (tmo_expired)
    );

    always_comb begin
        state_d       = state_q;
        src_d         = src_q;
        bus_valid_d   = bus_valid_q;
        bus_we_d      = bus_we_q;
        bus_addr_d    = bus_addr_q;
        bus_wdata_d   = bus_wdata_q;
        i_rdata_d     = i_rdata_q;
        d_rdata_d     = d_rdata_q;
        timeout_err_d = timeout_err_q;
        tmo_load      = 1'b0;
        tmo_en        = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (d_req) begin
                    state_d     = ARB_ADDR;
                    src_d       = SRC_D;
                    bus_valid_d = 1'b1;
                    bus_we_d    = d_we;
                    bus_addr_d  = d_addr;
                    bus_wdata_d = d_wdata;
                    tmo_load    = 1'b1;
                end else if (i_req) begin
                    state_d     = ARB_ADDR;
                    src_d       = SRC_I;
                    bus_valid_d = 1'b1;
                    bus_we_d    = 1'b0;
                    bus_addr_d  = i_addr;
                    bus_wdata_d = '0;
                    tmo_load    = 1'b1;
                end
            end
            ARB_ADDR: begin
                tmo_en = 1'b1;
                if (bus_ready) begin
                    state_d     = ARB_WAIT;
                    bus_valid_d = 1'b0;
                end else if (tmo_expired) begin
                    state_d       = ARB_RESP;
                    bus_valid_d   = 1'b0;
                    timeout_err_d = 1'b1;
                    if (!bus_we_q) begin
                        if (src_q == SRC_D) d_rdata_d = ERR_DATA;
                        else                i_rdata_d = ERR_DATA;
                    end
                end
            end
            ARB_WAIT: begin
                tmo_en = 1'b1;
                // A real response in the expiry cycle takes precedence.
                if (bus_rvalid) begin
                    state_d = ARB_RESP;
                    if (!bus_we_q) begin
                        if (src_q == SRC_D) d_rdata_d = bus_rdata;
                        else                i_rdata_d = bus_rdata;
                    end
                end else if (tmo_expired) begin
                    state_d       = ARB_RESP;
                    timeout_err_d = 1'b1;
                    if (!bus_we_q) begin
                        if (src_q == SRC_D) d_rdata_d = ERR_DATA;
                        else                i_rdata_d = ERR_DATA;
                    end
                end
            end
            ARB_RESP: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase

        i_done_d = (state_d == ARB_RESP) && (src_d == SRC_I);
        d_done_d = (state_d == ARB_RESP) && (src_d == SRC_D);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ARB_IDLE;
            src_q         <= SRC_I;
            bus_valid_q   <= 1'b0;
            bus_we_q      <= 1'b0;
            bus_addr_q    <= '0;
            bus_wdata_q   <= '0;
            i_rdata_q     <= '0;
            d_rdata_q     <= '0;
            i_done_q      <= 1'b0;
            d_done_q      <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            src_q         <= src_d;
            bus_valid_q   <= bus_valid_d;
            bus_we_q      <= bus_we_d;
            bus_addr_q    <= bus_addr_d;
            bus_wdata_q   <= bus_wdata_d;
            i_rdata_q     <= i_rdata_d;
            d_rdata_q     <= d_rdata_d;
            i_done_q      <= i_done_d;
            d_done_q      <= d_done_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus_valid   = bus_valid_q;
    assign bus_we      = bus_we_q;
    assign bus_addr    = bus_addr_q;
    assign bus_wdata   = bus_wdata_q;
    assign i_rdata     = i_rdata_q;
    assign d_rdata     = d_rdata_q;
    assign i_done      = i_done_q;
    assign d_done      = d_done_q;
    assign timeout_err = timeout_err_q;

    assign stall = (i_req & ~i_done_q) | (d_req & ~d_done_q);

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_bus_arbiter
// Brief   : Directed self-checking bench for mem_bus_arbiter (TIMEOUT=8).
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;

    logic        clk;
    logic        resetn;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_done;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_done;
    logic        stall;
    logic        bus_valid;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ready;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    mem_bus_arbiter #(
        .TIMEOUT  (8),
        .ERR_DATA (32'hdead_beef)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .i_req       (i_req),
        .i_addr      (i_addr),
        .i_rdata     (i_rdata),
        .i_done      (i_done),
        .d_req       (d_req),
        .d_we        (d_we),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_rdata     (d_rdata),
        .d_done      (d_done),
        .stall       (stall),
        .bus_valid   (bus_valid),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_ready   (bus_ready),
        .bus_rvalid  (bus_rvalid),
        .bus_rdata   (bus_rdata),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; outputs are
    // sampled at the falling edge, 4 units later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        #4;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        resetn     = 1'b0;
        i_req      = 1'b0;
        i_addr     = '0;
        d_req      = 1'b0;
        d_we       = 1'b0;
        d_addr     = '0;
        d_wdata    = '0;
        bus_ready  = 1'b0;
        bus_rvalid = 1'b0;
        bus_rdata  = '0;

        // Reset state
        repeat (2) tick();
        smp();
        chk("rst_bus_valid", bus_valid, 0);
        chk("rst_bus_we", bus_we, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_bus_wdata", bus_wdata, 0);
        chk("rst_i_done", i_done, 0);
        chk("rst_d_done", d_done, 0);
        chk("rst_i_rdata", i_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        chk("rst_timeout_err", timeout_err, 0);
        tick();
        resetn = 1'b1;

        // 1: minimum-latency fetch
        tick(); i_req = 1'b1; i_addr = 32'hbfc0_0000; smp();
        chk("t1_c0_stall", stall, 1);
        chk("t1_c0_bus_valid", bus_valid, 0);
        tick(); bus_ready = 1'b1; smp();
        chk("t1_c1_bus_valid", bus_valid, 1);
        chk("t1_c1_bus_addr", bus_addr, 32'hbfc0_0000);
        chk("t1_c1_bus_we", bus_we, 0);
        chk("t1_c1_stall", stall, 1);
        tick(); bus_ready = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h2408_0001; smp();
        chk("t1_c2_bus_valid", bus_valid, 0);
        chk("t1_c2_i_done", i_done, 0);
        chk("t1_c2_stall", stall, 1);
        tick(); bus_rvalid = 1'b0; bus_rdata = '0; smp();
        chk("t1_c3_i_done", i_done, 1);
        chk("t1_c3_i_rdata", i_rdata, 32'h2408_0001);
        chk("t1_c3_stall", stall, 0);
        chk("t1_c3_d_done", d_done, 0);
        tick(); i_req = 1'b0; smp();
        chk("t1_c4_i_done", i_done, 0);
        chk("t1_c4_i_rdata_held", i_rdata, 32'h2408_0001);

        // 2: simultaneous requests, data first then fetch
        tick();
        i_req = 1'b1; i_addr = 32'hbfc0_0004;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8000_0010;
        smp();
        chk("t2_c0_stall", stall, 1);
        tick(); bus_ready = 1'b1; smp();
        chk("t2_d_bus_addr", bus_addr, 32'h8000_0010);
        chk("t2_d_bus_we", bus_we, 0);
        tick(); bus_ready = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h1111_1111; smp();
        tick(); bus_rvalid = 1'b0; smp();
        chk("t2_d_done", d_done, 1);
        chk("t2_d_i_done", i_done, 0);
        chk("t2_d_rdata", d_rdata, 32'h1111_1111);
        chk("t2_d_stall_fetch_pending", stall, 1);
        tick(); d_req = 1'b0; smp();
        chk("t2_gap_bus_valid", bus_valid, 0);
        chk("t2_gap_d_done", d_done, 0);
        tick(); bus_ready = 1'b1; smp();
        chk("t2_i_bus_valid", bus_valid, 1);
        chk("t2_i_bus_addr", bus_addr, 32'hbfc0_0004);
        tick(); bus_ready = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h2222_2222; smp();
        tick(); bus_rvalid = 1'b0; smp();
        chk("t2_i_done", i_done, 1);
        chk("t2_i_rdata", i_rdata, 32'h2222_2222);
        chk("t2_d_rdata_held", d_rdata, 32'h1111_1111);
        tick(); i_req = 1'b0; smp();

        // 3: write with address phase stretched four cycles
        tick(); d_req = 1'b1; d_we = 1'b1; d_addr = 32'h8000_0020; d_wdata = 32'hcafe_f00d; smp();
        for (int k = 1; k <= 4; k++) begin
            tick(); smp();
            chk($sformatf("t3_wait%0d_bus_valid", k), bus_valid, 1);
            chk($sformatf("t3_wait%0d_bus_addr", k), bus_addr, 32'h8000_0020);
            chk($sformatf("t3_wait%0d_bus_wdata", k), bus_wdata, 32'hcafe_f00d);
            chk($sformatf("t3_wait%0d_bus_we", k), bus_we, 1);
        end
        tick(); bus_ready = 1'b1; smp();
        chk("t3_ready_bus_valid", bus_valid, 1);
        tick(); bus_ready = 1'b0; bus_rvalid = 1'b1; smp();
        chk("t3_ack_d_done", d_done, 0);
        tick(); bus_rvalid = 1'b0; smp();
        chk("t3_d_done", d_done, 1);
        chk("t3_d_rdata_untouched", d_rdata, 32'h1111_1111);
        chk("t3_timeout_err", timeout_err, 0);
        tick(); d_req = 1'b0; d_we = 1'b0; smp();

        // 4: read that never completes on the bus
        tick(); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8000_0030; smp();
        for (int k = 1; k <= 8; k++) begin
            tick(); smp();
            chk($sformatf("t4_cyc%0d_d_done", k), d_done, 0);
            chk($sformatf("t4_cyc%0d_bus_valid", k), bus_valid, 1);
        end
        tick(); smp();
        chk("t4_d_done", d_done, 1);
        chk("t4_d_rdata_err", d_rdata, 32'hdead_beef);
        chk("t4_timeout_err", timeout_err, 1);
        chk("t4_bus_valid", bus_valid, 0);
        tick(); d_req = 1'b0; smp();
        chk("t4_after_d_done", d_done, 0);
        tick(); i_req = 1'b1; i_addr = 32'hbfc0_0008; smp();
        tick(); bus_ready = 1'b1; smp();
        tick(); bus_ready = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h3333_3333; smp();
        tick(); bus_rvalid = 1'b0; smp();
        chk("t4_good_i_done", i_done, 1);
        chk("t4_good_i_rdata", i_rdata, 32'h3333_3333);
        chk("t4_sticky_err", timeout_err, 1);
        tick(); i_req = 1'b0; smp();

        // 5: reset asserted while waiting for the response
        tick(); i_req = 1'b1; i_addr = 32'hbfc0_000c; smp();
        tick(); bus_ready = 1'b1; smp();
        tick(); bus_ready = 1'b0; #1;
        resetn = 1'b0; #1;
        chk("t5_rst_bus_valid", bus_valid, 0);
        chk("t5_rst_i_done", i_done, 0);
        chk("t5_rst_timeout_err", timeout_err, 0);
        chk("t5_rst_i_rdata", i_rdata, 0);
        i_req = 1'b0;
        tick(); resetn = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'h4444_4444; smp();
        chk("t5_late_i_done", i_done, 0);
        chk("t5_late_bus_valid", bus_valid, 0);
        tick(); bus_rvalid = 1'b0; bus_rdata = '0; smp();
        chk("t5_post_i_done", i_done, 0);
        chk("t5_post_d_done", d_done, 0);
        chk("t5_post_i_rdata", i_rdata, 0);
        chk("t5_post_bus_valid", bus_valid, 0);

        // 6: requester address changes after grant
        tick(); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8000_0040; smp();
        tick(); d_addr = 32'h1234_5678; smp();
        chk("t6_c1_bus_addr", bus_addr, 32'h8000_0040);
        tick(); bus_ready = 1'b1; smp();
        chk("t6_c2_bus_addr", bus_addr, 32'h8000_0040);
        tick(); bus_ready = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h5555_5555; smp();
        tick(); bus_rvalid = 1'b0; smp();
        chk("t6_d_done", d_done, 1);
        chk("t6_d_rdata", d_rdata, 32'h5555_5555);
        tick(); d_req = 1'b0; smp();
        chk("t6_stall_idle", stall, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
